// File: rtl/wakeup_array_if.sv
// Dispatch, broadcast and select signal bundle for wakeup_array; slave = wakeup side.
// WAKEUP_STATS_EN adds the two statistics counters to the bundle.
interface wakeup_array_if #(
  parameter int RS_ENTRIES = 8,
  parameter int TAG_W      = 6,
  parameter int NUM_BCAST  = 2
);
  localparam int IDX_W = $clog2(RS_ENTRIES);

  logic                       flush;
  logic                       disp_valid;
  logic                       disp_ready;
  logic [IDX_W-1:0]           disp_index;
  logic [TAG_W-1:0]           disp_src1_tag;
  logic                       disp_src1_rdy;
  logic [TAG_W-1:0]           disp_src2_tag;
  logic                       disp_src2_rdy;
  logic [NUM_BCAST-1:0]       bcast_valid;
  logic [NUM_BCAST*TAG_W-1:0] bcast_tag;
  logic [RS_ENTRIES-1:0]      request_vector;
  logic                       grant_en;
  logic [IDX_W-1:0]           grant_index;
  logic [IDX_W:0]             occupancy;
  logic                       grant_err;
`ifdef WAKEUP_STATS_EN
  logic [31:0]                stat_full_cycles;
  logic [31:0]                stat_wakeups;
`endif

  modport master (
    output flush, disp_valid, disp_src1_tag, disp_src1_rdy, disp_src2_tag, disp_src2_rdy,
    output bcast_valid, bcast_tag, grant_en, grant_index,
`ifdef WAKEUP_STATS_EN
    input  stat_full_cycles, stat_wakeups,
`endif
    input  disp_ready, disp_index, request_vector, occupancy, grant_err
  );

  modport slave (
    input  flush, disp_valid, disp_src1_tag, disp_src1_rdy, disp_src2_tag, disp_src2_rdy,
    input  bcast_valid, bcast_tag, grant_en, grant_index,
`ifdef WAKEUP_STATS_EN
    output stat_full_cycles, stat_wakeups,
`endif
    output disp_ready, disp_index, request_vector, occupancy, grant_err
  );
endinterface

// File: rtl/wakeup_array.sv
// Reservation-station wakeup array: allocates entries, snoops result tags, requests select.
// Optional statistics counters are built only when WAKEUP_STATS_EN is defined.
module wakeup_array #(
  parameter int RS_ENTRIES = 8,
  parameter int TAG_W      = 6,
  parameter int NUM_BCAST  = 2
) (
  input logic          clk,
  input logic          rst,
  wakeup_array_if.slave io
);
  localparam int IDX_W = $clog2(RS_ENTRIES);
  localparam logic [IDX_W:0] OCC_ONE = 1;

  logic [RS_ENTRIES-1:0] valid_q, valid_d;
  logic [RS_ENTRIES-1:0] src1_rdy_q, src1_rdy_d, src2_rdy_q, src2_rdy_d;
  logic [TAG_W-1:0]      src1_tag_q [RS_ENTRIES];
  logic [TAG_W-1:0]      src1_tag_d [RS_ENTRIES];
  logic [TAG_W-1:0]      src2_tag_q [RS_ENTRIES];
  logic [TAG_W-1:0]      src2_tag_d [RS_ENTRIES];
  logic [IDX_W:0]        occ_q, occ_d;
  logic                  grant_err_q, grant_err_d;

  logic [IDX_W-1:0]      free_idx;
  logic                  free_any;
  logic                  grant_hit;
  logic                  disp_we, grant_ok;
  logic [RS_ENTRIES-1:0] wake1, wake2;
  logic                  byp1, byp2;

  function automatic logic bcast_hit(input logic [TAG_W-1:0] tag,
                                     input logic [NUM_BCAST-1:0] vld,
                                     input logic [NUM_BCAST*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_BCAST; k++)
      if (vld[k] && tags[k*TAG_W +: TAG_W] == tag) hit = 1'b1;
    return hit;
  endfunction

  // Scan downwards so the lowest free entry wins.
  always_comb begin
    free_idx  = '0;
    free_any  = 1'b0;
    grant_hit = 1'b0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = IDX_W'(i);
        free_any = 1'b1;
      end
      if (io.grant_index == IDX_W'(i) && valid_q[i]) grant_hit = 1'b1;
    end
  end

  always_comb begin
    disp_we     = io.disp_valid && free_any && !io.flush;
    grant_ok    = io.grant_en && grant_hit;
    grant_err_d = io.grant_en && !grant_hit && !io.flush;
    byp1        = !io.disp_src1_rdy && bcast_hit(io.disp_src1_tag, io.bcast_valid, io.bcast_tag);
    byp2        = !io.disp_src2_rdy && bcast_hit(io.disp_src2_tag, io.bcast_valid, io.bcast_tag);
    for (int i = 0; i < RS_ENTRIES; i++) begin
      wake1[i] = valid_q[i] && !src1_rdy_q[i] && !io.flush &&
                 bcast_hit(src1_tag_q[i], io.bcast_valid, io.bcast_tag);
      wake2[i] = valid_q[i] && !src2_rdy_q[i] && !io.flush &&
                 bcast_hit(src2_tag_q[i], io.bcast_valid, io.bcast_tag);
    end
    valid_d    = valid_q;
    src1_rdy_d = src1_rdy_q | wake1;
    src2_rdy_d = src2_rdy_q | wake2;
    src1_tag_d = src1_tag_q;
    src2_tag_d = src2_tag_q;
    if (grant_ok) valid_d[io.grant_index] = 1'b0;
    if (disp_we) begin
      valid_d[free_idx]    = 1'b1;
      src1_tag_d[free_idx] = io.disp_src1_tag;
      src2_tag_d[free_idx] = io.disp_src2_tag;
      src1_rdy_d[free_idx] = io.disp_src1_rdy || byp1;
      src2_rdy_d[free_idx] = io.disp_src2_rdy || byp2;
    end
    if (io.flush) valid_d = '0;
    occ_d = occ_q;
    if (io.flush)                 occ_d = '0;
    else if (disp_we && !grant_ok) occ_d = occ_q + OCC_ONE;
    else if (!disp_we && grant_ok) occ_d = occ_q - OCC_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      src1_rdy_q  <= '0;
      src2_rdy_q  <= '0;
      occ_q       <= '0;
      grant_err_q <= 1'b0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        src1_tag_q[i] <= '0;
        src2_tag_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      src1_rdy_q  <= src1_rdy_d;
      src2_rdy_q  <= src2_rdy_d;
      src1_tag_q  <= src1_tag_d;
      src2_tag_q  <= src2_tag_d;
      occ_q       <= occ_d;
      grant_err_q <= grant_err_d;
    end
  end

  assign io.disp_ready     = free_any;
  assign io.disp_index     = free_idx;
  assign io.request_vector = valid_q & src1_rdy_q & src2_rdy_q;
  assign io.occupancy      = occ_q;
  assign io.grant_err      = grant_err_q;

`ifdef WAKEUP_STATS_EN
  logic [31:0] stat_full_q, stat_full_d, stat_wake_q, stat_wake_d, wake_inc;
  logic [32:0] wake_sum;

  // Dispatch bypass counts only when the entry is actually written.
  always_comb begin
    wake_inc = 32'(disp_we && byp1) + 32'(disp_we && byp2);
    for (int i = 0; i < RS_ENTRIES; i++)
      wake_inc = wake_inc + 32'(wake1[i]) + 32'(wake2[i]);
    wake_sum    = {1'b0, stat_wake_q} + {1'b0, wake_inc};
    stat_wake_d = wake_sum[32] ? '1 : wake_sum[31:0];
    stat_full_d = stat_full_q;
    if (io.disp_valid && !free_any && stat_full_q != '1) stat_full_d = stat_full_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_full_q <= '0;
      stat_wake_q <= '0;
    end else begin
      stat_full_q <= stat_full_d;
      stat_wake_q <= stat_wake_d;
    end
  end

  assign io.stat_full_cycles = stat_full_q;
  assign io.stat_wakeups     = stat_wake_q;
`endif
endmodule

// File: tb/tb_wakeup_array.sv
// Scenario tasks plus a randomized run checked against an entry-list reference model.
module tb_wakeup_array;
  localparam int N = 8;
  localparam int TW = 6;
  localparam int NB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wakeup_array_if #(.RS_ENTRIES(N), .TAG_W(TW), .NUM_BCAST(NB)) io ();
  wakeup_array #(.RS_ENTRIES(N), .TAG_W(TW), .NUM_BCAST(NB)) dut (.clk(clk), .rst(rst), .io(io));

  // Reference model: one record per entry, updated once per clock edge.
  bit          m_v [N];
  bit          m_r1 [N];
  bit          m_r2 [N];
  bit [TW-1:0] m_t1 [N];
  bit [TW-1:0] m_t2 [N];
  bit          m_gerr;
  int          m_full;
  int          m_wake;

  function automatic bit bhit(input bit [TW-1:0] t);
    for (int k = 0; k < NB; k++)
      if (io.bcast_valid[k] && io.bcast_tag[k*TW +: TW] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_lowfree();
    for (int i = 0; i < N; i++) if (!m_v[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] m_req();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_v[i] && m_r1[i] && m_r2[i];
    return r;
  endfunction

  function automatic logic [3:0] m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_v[i]);
    return 4'(c);
  endfunction

  task automatic model_tick();
    int lf = m_lowfree();
    int gi = int'(io.grant_index);
    if (io.disp_valid && lf < 0) m_full++;
    if (io.flush) begin
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
      m_gerr = 1'b0;
    end else begin
      m_gerr = io.grant_en && !m_v[gi];
      for (int i = 0; i < N; i++) begin
        if (m_v[i] && !m_r1[i] && bhit(m_t1[i])) begin m_r1[i] = 1'b1; m_wake++; end
        if (m_v[i] && !m_r2[i] && bhit(m_t2[i])) begin m_r2[i] = 1'b1; m_wake++; end
      end
      if (io.grant_en && m_v[gi]) m_v[gi] = 1'b0;
      if (io.disp_valid && lf >= 0) begin
        m_v[lf]  = 1'b1;
        m_t1[lf] = io.disp_src1_tag;
        m_t2[lf] = io.disp_src2_tag;
        m_r1[lf] = io.disp_src1_rdy || bhit(io.disp_src1_tag);
        m_r2[lf] = io.disp_src2_rdy || bhit(io.disp_src2_tag);
        if (!io.disp_src1_rdy && bhit(io.disp_src1_tag)) m_wake++;
        if (!io.disp_src2_rdy && bhit(io.disp_src2_tag)) m_wake++;
      end
    end
  endtask

  task automatic clear_inputs();
    io.flush = 1'b0; io.disp_valid = 1'b0;
    io.disp_src1_tag = '0; io.disp_src1_rdy = 1'b0;
    io.disp_src2_tag = '0; io.disp_src2_rdy = 1'b0;
    io.bcast_valid = '0; io.bcast_tag = '0;
    io.grant_en = 1'b0; io.grant_index = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin m_v[i] = 0; m_r1[i] = 0; m_r2[i] = 0; m_t1[i] = 0; m_t2[i] = 0; end
    m_gerr = 0; m_full = 0; m_wake = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic dispatch(input bit [TW-1:0] t1, input bit r1, input bit [TW-1:0] t2, input bit r2);
    io.disp_valid = 1'b1;
    io.disp_src1_tag = t1; io.disp_src1_rdy = r1;
    io.disp_src2_tag = t2; io.disp_src2_rdy = r2;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #3;
    checks++; if (io.request_vector !== 8'h00) begin errors++; $display("FAIL reset_req got=%h exp=00", io.request_vector); end
    checks++; if (io.occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", io.occupancy); end
    checks++; if (io.grant_err !== 1'b0) begin errors++; $display("FAIL reset_gerr got=%b exp=0", io.grant_err); end
    checks++; if (io.disp_ready !== 1'b1 || io.disp_index !== 3'd0) begin
      errors++; $display("FAIL reset_alloc got rdy=%b idx=%0d exp rdy=1 idx=0", io.disp_ready, io.disp_index); end
    apply_reset();
  endtask

  task automatic test_dispatch_ready();
    apply_reset();
    dispatch(6'd1, 1'b1, 6'd2, 1'b1);
    #1;
    checks++; if (io.disp_index !== 3'd0) begin errors++; $display("FAIL disp_idx0 got=%0d exp=0", io.disp_index); end
    cycle();
    checks++; if (io.request_vector !== 8'h01) begin errors++; $display("FAIL disp_req got=%h exp=01", io.request_vector); end
    checks++; if (io.occupancy !== 4'd1) begin errors++; $display("FAIL disp_occ got=%0d exp=1", io.occupancy); end
  endtask

  task automatic test_bcast_wakeup();
    apply_reset();
    dispatch(6'd5, 1'b0, 6'd3, 1'b1);
    cycle();
    cycle();
    io.bcast_valid = 2'b10;
    io.bcast_tag = {6'd5, 6'd0};
    #1;
    checks++; if (io.request_vector !== 8'h00) begin errors++; $display("FAIL bcast_pre got=%h exp=00", io.request_vector); end
    cycle();
    checks++; if (io.request_vector !== 8'h01) begin errors++; $display("FAIL bcast_wake got=%h exp=01", io.request_vector); end
  endtask

  task automatic test_bypass();
    apply_reset();
    dispatch(6'd4, 1'b1, 6'd9, 1'b0);
    io.bcast_valid = 2'b01;
    io.bcast_tag = {6'd0, 6'd9};
    cycle();
    checks++; if (io.request_vector !== 8'h01) begin errors++; $display("FAIL bypass got=%h exp=01", io.request_vector); end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < N; i++) begin
      dispatch(6'($urandom_range(0, 63)), 1'b1, 6'($urandom_range(0, 63)), 1'b1);
      #1;
      checks++; if (io.disp_index !== 3'(i)) begin errors++; $display("FAIL fill_idx got=%0d exp=%0d", io.disp_index, i); end
      cycle();
    end
    checks++; if (io.disp_ready !== 1'b0 || io.occupancy !== 4'd8) begin
      errors++; $display("FAIL full got rdy=%b occ=%0d exp rdy=0 occ=8", io.disp_ready, io.occupancy); end
    dispatch(6'd7, 1'b1, 6'd7, 1'b1);
    cycle();
    checks++; if (io.occupancy !== 4'd8 || io.request_vector !== 8'hff) begin
      errors++; $display("FAIL full_ignore got occ=%0d req=%h exp occ=8 req=ff", io.occupancy, io.request_vector); end
    io.grant_en = 1'b1; io.grant_index = 3'd3;
    cycle();
    checks++; if (io.disp_ready !== 1'b1 || io.disp_index !== 3'd3 || io.occupancy !== 4'd7) begin
      errors++; $display("FAIL regrant got rdy=%b idx=%0d occ=%0d exp rdy=1 idx=3 occ=7", io.disp_ready, io.disp_index, io.occupancy); end
  endtask

  task automatic test_grant_err();
    apply_reset();
    for (int i = 0; i < 3; i++) begin dispatch(6'd1, 1'b1, 6'd1, 1'b1); cycle(); end
    io.grant_en = 1'b1; io.grant_index = 3'd6;
    cycle();
    checks++; if (io.grant_err !== 1'b1) begin errors++; $display("FAIL gerr_pulse got=%b exp=1", io.grant_err); end
    checks++; if (io.occupancy !== 4'd3 || io.request_vector !== 8'h07) begin
      errors++; $display("FAIL gerr_state got occ=%0d req=%h exp occ=3 req=07", io.occupancy, io.request_vector); end
    cycle();
    checks++; if (io.grant_err !== 1'b0) begin errors++; $display("FAIL gerr_clear got=%b exp=0", io.grant_err); end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 5; i++) begin dispatch(6'd2, 1'b1, 6'd2, 1'b1); cycle(); end
    dispatch(6'd2, 1'b1, 6'd2, 1'b1);
    io.flush = 1'b1; io.grant_en = 1'b1; io.grant_index = 3'd7;
    cycle();
    checks++; if (io.occupancy !== 4'd0 || io.request_vector !== 8'h00 || io.grant_err !== 1'b0) begin
      errors++; $display("FAIL flush got occ=%0d req=%h gerr=%b exp 0/00/0", io.occupancy, io.request_vector, io.grant_err); end
    checks++; if (io.disp_ready !== 1'b1 || io.disp_index !== 3'd0) begin
      errors++; $display("FAIL flush_alloc got rdy=%b idx=%0d exp rdy=1 idx=0", io.disp_ready, io.disp_index); end
  endtask

  task automatic test_random();
    int lf;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      io.disp_valid    = ($urandom_range(0, 9) < 6);
      io.disp_src1_tag = 6'($urandom_range(0, 7));
      io.disp_src1_rdy = 1'($urandom_range(0, 1));
      io.disp_src2_tag = 6'($urandom_range(0, 7));
      io.disp_src2_rdy = 1'($urandom_range(0, 1));
      io.bcast_valid   = 2'($urandom_range(0, 3));
      io.bcast_tag     = 12'({$urandom_range(0, 7), 6'($urandom_range(0, 7))});
      io.grant_en      = ($urandom_range(0, 9) < 4);
      io.grant_index   = 3'($urandom_range(0, 7));
      io.flush         = ($urandom_range(0, 49) == 0);
      #1;
      lf = m_lowfree();
      checks++; if (io.disp_ready !== (lf >= 0) || io.disp_index !== 3'((lf < 0) ? 0 : lf)) begin
        errors++; $display("FAIL rnd_alloc c=%0d got rdy=%b idx=%0d exp lowfree=%0d", c, io.disp_ready, io.disp_index, lf); end
      checks++; if (io.request_vector !== m_req()) begin
        errors++; $display("FAIL rnd_req c=%0d got=%h exp=%h", c, io.request_vector, m_req()); end
      checks++; if (io.occupancy !== m_count() || io.grant_err !== m_gerr) begin
        errors++; $display("FAIL rnd_occ c=%0d got occ=%0d gerr=%b exp occ=%0d gerr=%b", c, io.occupancy, io.grant_err, m_count(), m_gerr); end
      cycle();
    end
`ifdef WAKEUP_STATS_EN
    checks++; if (io.stat_full_cycles !== 32'(m_full) || io.stat_wakeups !== 32'(m_wake)) begin
      errors++; $display("FAIL stats got full=%0d wake=%0d exp full=%0d wake=%0d", io.stat_full_cycles, io.stat_wakeups, m_full, m_wake); end
`endif
  endtask

  task automatic test_async_reset();
    dispatch(6'd1, 1'b1, 6'd1, 1'b1);
    cycle();
    dispatch(6'd1, 1'b1, 6'd1, 1'b1);
    io.grant_en = 1'b1; io.grant_index = 3'd7;
    cycle();
    #2 rst = 1'b1;
    #1;
    checks++; if (io.request_vector !== 8'h00 || io.occupancy !== 4'd0 || io.grant_err !== 1'b0) begin
      errors++; $display("FAIL arst_out got req=%h occ=%0d gerr=%b exp 00/0/0", io.request_vector, io.occupancy, io.grant_err); end
    checks++; if (io.disp_ready !== 1'b1 || io.disp_index !== 3'd0) begin
      errors++; $display("FAIL arst_alloc got rdy=%b idx=%0d exp rdy=1 idx=0", io.disp_ready, io.disp_index); end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_dispatch_ready();
    test_bcast_wakeup();
    test_bypass();
    test_full();
    test_grant_err();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wakeup_array.md
Name: wakeup_array

Overview:
- Reservation-station wakeup array. It sits between Dispatch and the Select stage, on the Wakeup side of the wakeup/select interface.
- Holds source-operand tags and ready bits per RS entry, allocates free entries to dispatch, and snoops result-tag broadcasts.
- Drives the request vector to Select and consumes its grant to free entries.
- The allocated entry index is the same index used to write the payload RAM.

Parameters:
- RS_ENTRIES, 8, number of reservation-station entries
- TAG_W, 6, physical-register tag width
- NUM_BCAST, 2, number of result-tag broadcast ports per cycle
- IDX_W, $clog2(RS_ENTRIES), entry index width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  invalidate all entries (pipeline squash)
- disp_valid  in  1  dispatch requests an entry this cycle
- disp_ready  out  1  at least one free entry exists
- disp_index  out  IDX_W  entry allocated to dispatch (payload RAM index)
- disp_src1_tag  in  TAG_W  source 1 tag
- disp_src1_rdy  in  1  source 1 already available
- disp_src2_tag  in  TAG_W  source 2 tag
- disp_src2_rdy  in  1  source 2 already available
- bcast_valid  in  NUM_BCAST  broadcast port valid bits
- bcast_tag  in  NUM_BCAST*TAG_W  broadcast tags; port k occupies bits [k*TAG_W +: TAG_W]
- request_vector  out  RS_ENTRIES  entry i is valid and both sources are ready
- grant_en  in  1  Select granted an entry
- grant_index  in  IDX_W  granted entry
- occupancy  out  IDX_W+1  number of valid entries
- grant_err  out  1  registered pulse: grant hit an invalid entry

Behaviour:
- Per-entry state: valid, src1_tag, src1_rdy, src2_tag, src2_rdy.
- Reset (async, rst=1): all state cleared.
  - Outputs during reset: request_vector=0, occupancy=0, grant_err=0, disp_ready=1, disp_index=0.
- Allocation (combinational):
  - disp_index = lowest-numbered invalid entry.
  - disp_ready = |~valid.
  - When full: disp_ready=0 and disp_index=0.
- Dispatch write:
  - Occurs at posedge when disp_valid && disp_ready && !flush.
  - Sets valid and stores both tags.
  - Each srcN_rdy stored = disp_srcN_rdy OR (any bcast_valid[k] with bcast_tag[k]==disp_srcN_tag) in the same cycle. This bypass prevents missed wakeups.
  - disp_valid while !disp_ready is ignored and causes no state change.
- Wakeup:
  - Each cycle, for every valid entry with srcN_rdy=0, any matching valid broadcast sets srcN_rdy at the next edge.
  - Multiple ports matching the same source is legal.
  - Already-ready sources are unaffected.
- request_vector:
  - Combinational from registered state: valid & src1_rdy & src2_rdy.
  - Dispatch-to-request latency is 1 cycle if both sources are ready at dispatch.
  - Broadcast-to-request latency is 1 cycle.
- Grant:
  - At posedge, grant_en clears valid[grant_index]. The entry is re-allocatable the following cycle.
  - A grant to an invalid entry changes no state and sets grant_err=1 for one cycle.
  - Grant and dispatch in the same cycle never target the same index, since dispatch only picks entries that are invalid at cycle start.
- Flush:
  - At posedge, all valid bits are cleared.
  - Flush has priority over a same-cycle dispatch and grant; grant_err is not raised under flush.
- Occupancy:
  - Registered count of valid entries.
  - Updated by +1 on dispatch write and −1 on valid grant, both in the same cycle (net 0).
  - Set to 0 on flush.
- Occupancy never exceeds RS_ENTRIES and never underflows.

Optional Feature:
- Macro: WAKEUP_STATS_EN.
- Defined:
  - Adds output stat_full_cycles (32 bits): counts cycles where disp_valid && !disp_ready.
  - Adds output stat_wakeups (32 bits): counts source-ready transitions caused by broadcast, including dispatch bypass.
  - Both counters saturate at all-ones, async reset to 0, and are unaffected by flush.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- Reset, then dispatch src1_rdy=1, src2_rdy=1 → disp_index=0 at dispatch; next cycle request_vector=8'b0000_0001, occupancy=1.
- Dispatch entry with src1 tag 5 not ready; two cycles later bcast_valid=2'b10, bcast_tag port1=5 → request bit 0 rises the cycle after the broadcast.
- Dispatch with src2 tag 9 not ready while bcast port0 tag=9 in the same cycle → request asserted the next cycle (bypass), with no further broadcast needed.
- Fill all 8 entries → disp_ready=0, occupancy=8; further disp_valid → no change. Grant index 3 → next cycle disp_ready=1, disp_index=3.
- Grant an invalid index 6 → grant_err pulses 1 cycle; valid, occupancy and request_vector unchanged.
- With 5 entries valid, assert flush together with disp_valid and grant_en → next cycle occupancy=0, request_vector=0, grant_err=0. Assert rst mid-stream → outputs return to reset values immediately, without waiting for a clock edge.
